// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

    // Cut-through forwards beats as soon as they are stored; store-and-forward
    // holds a packet back until its tlast beat has been written.
    typedef enum logic {
        MODE_CUT_THROUGH,
        MODE_STORE_FORWARD
    } fifo_mode_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module axis_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one entry per accepted beat; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with cut-through or store-and-forward release and
// occupancy / packet-count status.
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int         TDATA_WIDTH = 8,
    parameter int         FIFO_DEPTH  = 16,
    parameter fifo_mode_e MODE        = MODE_CUT_THROUGH,
    parameter int         AF_THRESH   = 2,
    localparam int        TKEEP_WIDTH = TDATA_WIDTH / 8,
    localparam int        PW          = ptr_width(FIFO_DEPTH)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [PW-1:0]          occupancy,
    output logic [PW-1:0]          pkt_count,
    output logic                   almost_full
);

    localparam int            AW      = PW - 1;
    localparam int            EW      = TKEEP_WIDTH + 1 + TDATA_WIDTH;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_V = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_V    = PW'(AF_THRESH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occ_q;
    logic [PW-1:0] pkt_q;
    logic          release_q;
    logic          live_q;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          wr_last;
    logic          rd_last;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    // live_q keeps tready low while in reset and for the edge that leaves it.
    assign s_axis_tready = live_q && !full;
    // Release lets an oversize packet drain as cut-through so a full FIFO with
    // no complete packet cannot deadlock.
    assign m_axis_tvalid = !empty && ((MODE == MODE_CUT_THROUGH) || (pkt_q != '0) || release_q);

    assign wr_en   = s_axis_tvalid && s_axis_tready;
    assign rd_en   = m_axis_tvalid && m_axis_tready;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && m_axis_tlast;

    assign wr_entry = {s_axis_tkeep, s_axis_tlast, s_axis_tdata};
    assign {m_axis_tkeep, m_axis_tlast, m_axis_tdata} = rd_entry;

    assign occupancy   = occ_q;
    assign pkt_count   = pkt_q;
    assign almost_full = (DEPTH_V - occ_q) <= AF_V;

    axis_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

    // Advance pointers, track occupancy/packet count and the release flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ_q     <= '0;
            pkt_q     <= '0;
            release_q <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (wr_en && !rd_en) begin
                occ_q <= occ_q + ONE;
            end else if (!wr_en && rd_en) begin
                occ_q <= occ_q - ONE;
            end
            if (wr_last && !rd_last) begin
                pkt_q <= pkt_q + ONE;
            end else if (!wr_last && rd_last) begin
                pkt_q <= pkt_q - ONE;
            end
            if (rd_last) begin
                release_q <= 1'b0;
            end else if ((MODE == MODE_STORE_FORWARD) && full && (pkt_q == '0)) begin
                release_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench: one cut-through and one store-and-forward FIFO (depth 8), each
// compared every cycle against a queue-based reference model.
module tb_axis_packet_fifo;
    import axis_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int AF    = 2;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] s_tdata  [2];
    logic [1:0]  s_tkeep  [2];
    logic        s_tlast  [2];
    logic        s_tvalid [2];
    logic        s_tready [2];
    logic [15:0] m_tdata  [2];
    logic [1:0]  m_tkeep  [2];
    logic        m_tlast  [2];
    logic        m_tvalid [2];
    logic        m_tready [2];
    logic [3:0]  occ      [2];
    logic [3:0]  pkt      [2];
    logic        af       [2];

    beat_t mq [2][$];
    bit    live [2];
    bit    rel  [2];
    bit    acc  [2];
    int    checks = 0;
    int    failures = 0;
    string phase = "reset";

    always #5 aclk = ~aclk;

    axis_packet_fifo #(.TDATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .MODE(MODE_CUT_THROUGH), .AF_THRESH(AF)) u_ct (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tlast(s_tlast[0]),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .occupancy(occ[0]), .pkt_count(pkt[0]), .almost_full(af[0]));

    axis_packet_fifo #(.TDATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .MODE(MODE_STORE_FORWARD), .AF_THRESH(AF)) u_sf (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tlast(s_tlast[1]),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .occupancy(occ[1]), .pkt_count(pkt[1]), .almost_full(af[1]));

    // ---------------- reference model ----------------
    function automatic int nlast(int i);
        int n = 0;
        for (int j = 0; j < mq[i].size(); j++) if (mq[i][j].l) n++;
        return n;
    endfunction

    function automatic bit mdl_ready(int i);
        return live[i] && (mq[i].size() < DEPTH);
    endfunction

    // Instance 1 is store-and-forward: it needs a whole packet or release.
    function automatic bit mdl_valid(int i);
        if (mq[i].size() == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (nlast(i) > 0) || rel[i];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            live[i] = 1'b0;
            rel[i]  = 1'b0;
            acc[i]  = 1'b0;
        end
    endtask

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s[%0d] observed=0x%0h expected=0x%0h", phase, tag, i, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int sz = mq[i].size();
            chk("s_tready", i, s_tready[i], mdl_ready(i));
            chk("m_tvalid", i, m_tvalid[i], mdl_valid(i));
            chk("occupancy", i, occ[i], sz);
            chk("pkt_count", i, pkt[i], nlast(i));
            chk("almost_full", i, af[i], (DEPTH - sz) <= AF);
            if (mdl_valid(i)) begin
                chk("m_tdata", i, m_tdata[i], mq[i][0].d);
                chk("m_tkeep", i, m_tkeep[i], mq[i][0].k);
                chk("m_tlast", i, m_tlast[i], mq[i][0].l);
            end
        end
    endtask

    // One clock: decide handshakes from the model, apply them at the edge,
    // then compare every DUT output shortly after the edge.
    task automatic tick();
        bit w [2];
        bit r [2];
        for (int i = 0; i < 2; i++) begin
            w[i] = s_tvalid[i] && mdl_ready(i);
            r[i] = mdl_valid(i) && m_tready[i];
        end
        @(posedge aclk);
        if (!aresetn) begin
            mdl_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit stuck = (mq[i].size() == DEPTH) && (nlast(i) == 0);
                bit popped_last = 1'b0;
                if (r[i]) begin
                    beat_t b = mq[i].pop_front();
                    popped_last = b.l;
                end
                if (popped_last) rel[i] = 1'b0;
                else if (i == 1 && stuck) rel[i] = 1'b1;
                if (w[i]) mq[i].push_back('{d: s_tdata[i], k: s_tkeep[i], l: s_tlast[i]});
                acc[i]  = w[i];
                live[i] = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic send_beat(int i, logic [15:0] d, logic [1:0] k, logic l);
        int n = 0;
        s_tdata[i] = d; s_tkeep[i] = k; s_tlast[i] = l; s_tvalid[i] = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc[i] && n < 40);
        if (!acc[i]) chk("accept_timeout", i, 0, 1);
        s_tvalid[i] = 1'b0;
    endtask

    task automatic new_beat(int i, bit rand_last);
        s_tdata[i] = 16'($urandom);
        s_tkeep[i] = 2'($urandom_range(0, 3));
        s_tlast[i] = rand_last ? ($urandom_range(0, 2) == 0) : 1'b0;
    endtask

    // Continuous producer for n cycles; data only changes after acceptance.
    task automatic stream(int i, int n, bit rand_last);
        new_beat(i, rand_last);
        s_tvalid[i] = 1'b1;
        repeat (n) begin
            tick();
            if (acc[i]) new_beat(i, rand_last);
        end
        s_tvalid[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_tdata[i] = '0; s_tkeep[i] = '0; s_tlast[i] = 1'b0;
            s_tvalid[i] = 1'b0; m_tready[i] = 1'b0;
        end
        mdl_reset();

        // Reset held, then released.
        idle(2);
        aresetn = 1'b1;
        idle(2);

        // Cut-through three-beat packet with a ready consumer.
        phase = "ct_basic";
        m_tready[0] = 1'b1;
        send_beat(0, 16'h0011, 2'b01, 1'b0);
        send_beat(0, 16'h0022, 2'b11, 1'b0);
        send_beat(0, 16'h0033, 2'b10, 1'b1);
        idle(4);

        // Fill to full with the consumer stalled, then free one slot.
        phase = "ct_full";
        m_tready[0] = 1'b0;
        stream(0, 10, 1'b0);
        m_tready[0] = 1'b1;
        tick();
        m_tready[0] = 1'b0;
        idle(2);
        m_tready[0] = 1'b1;
        idle(10);

        // Store-and-forward: nothing leaves until the tlast beat lands.
        phase = "sf_packet";
        m_tready[1] = 1'b1;
        send_beat(1, 16'hA001, 2'b11, 1'b0);
        send_beat(1, 16'hA002, 2'b11, 1'b0);
        send_beat(1, 16'hA003, 2'b01, 1'b0);
        idle(5);
        send_beat(1, 16'hA004, 2'b11, 1'b1);
        idle(6);

        // Oversize packet must drain through the release path.
        phase = "sf_oversize";
        for (int b = 0; b < 12; b++)
            send_beat(1, 16'hB000 + 16'(b), 2'($urandom_range(0, 3)), b == 11);
        idle(12);

        // Simultaneous read/write around occupancy 4 with random tkeep/tlast.
        phase = "rw_prefill";
        m_tready[0] = 1'b0;
        m_tready[1] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            send_beat(0, 16'(b + 16'hC0), 2'($urandom_range(0, 3)), b == 1);
            send_beat(1, 16'(b + 16'hD0), 2'($urandom_range(0, 3)), b == 1);
        end
        phase = "rw_ct";
        m_tready[0] = 1'b1;
        stream(0, 16, 1'b1);
        phase = "rw_sf";
        m_tready[1] = 1'b1;
        stream(1, 16, 1'b1);
        phase = "rw_drain";
        s_tvalid[1] = 1'b1; s_tlast[1] = 1'b1; s_tdata[1] = 16'hEEEE; s_tkeep[1] = 2'b11;
        tick();
        s_tvalid[1] = 1'b0;
        idle(12);

        // Asynchronous reset in the middle of a partially stored packet.
        phase = "mid_reset";
        m_tready[0] = 1'b0;
        stream(0, 5, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        mdl_reset();
        check_all();
        idle(2);
        aresetn = 1'b1;
        tick();
        phase = "post_reset";
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        send_beat(0, 16'h0F01, 2'b11, 1'b0);
        send_beat(0, 16'h0F02, 2'b01, 1'b0);
        send_beat(0, 16'h0F03, 2'b10, 1'b1);
        send_beat(1, 16'h1F01, 2'b11, 1'b0);
        send_beat(1, 16'h1F02, 2'b10, 1'b1);
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_packet_fifo.md
# axis_packet_fifo

Parametrised AXI4-Stream FIFO carrying tdata, tkeep and tlast, with a selectable cut-through or store-and-forward (packet) mode and occupancy/packet-count status. It is the general successor to the fixed-width single-mode stream FIFO. It sits between an AXI4-Stream producer (slave side) and consumer (master side) in the same clock domain.

## Interface
- TDATA_WIDTH, 8: tdata width in bits, multiple of 8.
- TKEEP_WIDTH, TDATA_WIDTH/8: derived; not overridden.
- FIFO_DEPTH, 16: entries; power of two, ≥ 2.
- MODE, MODE_CUT_THROUGH: MODE_CUT_THROUGH or MODE_STORE_FORWARD.
- AF_THRESH, 2: almost_full asserts when free entries ≤ AF_THRESH.

Ports:
- aclk, in, 1, sole clock; all logic on rising edge.
- aresetn, in, 1, asynchronous active-low reset.
- s_axis_tdata, in, TDATA_WIDTH, input beat data.
- s_axis_tkeep, in, TKEEP_WIDTH, input byte enables.
- s_axis_tlast, in, 1, input end of packet.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, FIFO can accept a beat.
- m_axis_tdata, out, TDATA_WIDTH, output beat data.
- m_axis_tkeep, out, TKEEP_WIDTH, output byte enables.
- m_axis_tlast, out, 1, output end of packet.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, consumer accepts a beat.
- occupancy, out, $clog2(FIFO_DEPTH)+1, stored beats.
- pkt_count, out, $clog2(FIFO_DEPTH)+1, complete packets stored (number of stored tlast beats).
- almost_full, out, 1, free entries ≤ AF_THRESH.

## Operation
- Storage: each entry holds {tkeep, tlast, tdata}.
- Pointers: write and read pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full when the address bits are equal and the MSBs differ.
  - Empty when all bits are equal.
- Write: occurs when s_axis_tvalid & s_axis_tready. s_axis_tready = !full; there is no bypass when full.
- Read: occurs when m_axis_tvalid & m_axis_tready. m_axis_tdata/tkeep/tlast always reflect the entry at the read pointer.
- occupancy: +1 on write only, −1 on read only, unchanged on both.
- pkt_count: +1 on a write with tlast, −1 on a read with tlast, unchanged when both happen together.
- m_axis_tvalid in MODE_CUT_THROUGH: !empty.
- m_axis_tvalid in MODE_STORE_FORWARD: !empty & (pkt_count != 0 | release).
- Oversize-packet release (store-and-forward only):
  - When full and pkt_count == 0, set the release flag.
  - Clear release on the read of a tlast beat.
  - While release is set, the FIFO behaves as cut-through, so it cannot deadlock.
- Once m_axis_tvalid is asserted, it and the data hold stable until the handshake completes. No AXI-Stream rule violations are permitted.
- tkeep is passed through unchanged; no null-beat filtering.

## Timing
- Reset (aresetn low, async): pointers = 0, occupancy = 0, pkt_count = 0, release = 0, m_axis_tvalid = 0, s_axis_tready = 0, almost_full = 0. s_axis_tready rises the first cycle after aresetn deasserts.
- Cut-through latency:
  - Beat written at edge N is visible with m_axis_tvalid = 1 after edge N.
  - No same-cycle write-through on empty.
- Store-and-forward latency: m_axis_tvalid rises after the edge that writes the tlast beat, presenting the first beat of that packet.
- Throughput: one beat per cycle sustained in both modes when neither side stalls.
- Status: occupancy, pkt_count and almost_full update on the same edge as the handshake that changes them.
- Reset mid-packet: all stored data is discarded and any partial packet is lost. There is no recovery state.

## Structure
- Package axis_fifo_pkg holds:
  - typedef enum fifo_mode_e {MODE_CUT_THROUGH, MODE_STORE_FORWARD};
  - the pointer-width helper function.
- Sub-module axis_fifo_ram: simple dual-port memory, synchronous write, asynchronous read, parametrised width and depth.
- axis_packet_fifo holds the pointers, counters, release flag and handshake logic.

## Test plan
- Cut-through, DEPTH=8, slave always ready: send 3 beats 0x11, 0x22, 0x33 with tlast on 0x33 → output identical, first beat valid 1 cycle after acceptance, pkt_count peaks at 1.
- Full boundary, DEPTH=8, m_axis_tready = 0: write 8 beats → s_axis_tready drops after the 8th, occupancy = 8, almost_full asserted from occupancy 6 (AF_THRESH=2). Then one read → s_axis_tready = 1 next cycle.
- Store-and-forward: send 4-beat packet A with a 5-cycle gap before its tlast → m_axis_tvalid stays 0 until after the tlast edge, then A streams out back-to-back.
- Oversize packet, store-and-forward, DEPTH=8: send a 12-beat packet → release set at occupancy 8 with pkt_count 0, all 12 beats delivered in order, release cleared after the tlast read.
- Simultaneous read/write at occupancy 4, random tkeep → occupancy stays 4, pkt_count unchanged unless tlast is on exactly one side; scoreboard matches data/tkeep/tlast.
- Reset asserted mid-packet with occupancy 5 → all outputs return to reset values asynchronously, and the next packet after reset passes intact.
